// File: rtl/nmea_pkg.sv
// Shared NMEA definitions: ASCII constants, parser state encoding and
// per-field digit limits used by the sentence field parsers.
package nmea_pkg;

    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMMA0  = 3'd1,
        FIELDS  = 3'd2,
        CK_HI   = 3'd3,
        CK_LO   = 3'd4,
        WAIT_CR = 3'd5
    } state_t;

    // Digit limits per field; a counter value of DIGIT_SAT never matches any.
    localparam logic [2:0] TIME_DIGITS  = 3'd6;
    localparam logic [2:0] FRAC_MAX     = 3'd3;
    localparam logic [2:0] DAY_DIGITS   = 3'd2;
    localparam logic [2:0] MONTH_DIGITS = 3'd2;
    localparam logic [2:0] YEAR_DIGITS  = 3'd4;
    localparam logic [2:0] ZONE_MAX     = 3'd3;
    localparam logic [2:0] LAST_FIELD   = 3'd5;
    localparam logic [2:0] DIGIT_SAT    = 3'd7;

    function automatic logic is_dec_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

    function automatic logic [2:0] digit_inc(input logic [2:0] cnt);
        return (cnt == DIGIT_SAT) ? DIGIT_SAT : (cnt + 3'd1);
    endfunction

    // True when the characters collected in the current field form a legal
    // count. frac/int_ok only matter for the time field (hhmmss[.fff]).
    function automatic logic field_count_ok(input logic [2:0] field,
                                            input logic [2:0] digit,
                                            input logic       frac,
                                            input logic       int_ok);
        logic ok;
        case (field)
            3'd0:    ok = frac ? (int_ok && (digit <= FRAC_MAX)) : (digit == TIME_DIGITS);
            3'd1:    ok = (digit == DAY_DIGITS);
            3'd2:    ok = (digit == MONTH_DIGITS);
            3'd3:    ok = (digit == YEAR_DIGITS);
            3'd4,
            3'd5:    ok = (digit <= ZONE_MAX);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/nmea_hex_nibble.sv
// ASCII hex character to 4-bit value; valid flags '0'-'9', 'A'-'F', 'a'-'f'.
module nmea_hex_nibble (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       valid
);

    // Decode one ASCII character into its hex value.
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            nibble = ch[3:0];
            valid  = 1'b1;
        end else if ((ch >= 8'h41) && (ch <= 8'h46)) begin
            nibble = ch[3:0] + 4'd9;
            valid  = 1'b1;
        end else if ((ch >= 8'h61) && (ch <= 8'h66)) begin
            nibble = ch[3:0] + 4'd9;
            valid  = 1'b1;
        end else begin
            nibble = 4'h0;
            valid  = 1'b0;
        end
    end

endmodule

// File: rtl/gpzda_field_parser.sv
// Parses the body of a $GPZDA sentence after the header comparer fires:
// extracts BCD time/date into shadow registers, verifies the XOR checksum,
// and publishes the timestamp with a done pulse (or flags error).
module gpzda_field_parser
    import nmea_pkg::*;
#(
    parameter int unsigned  B           = 8,
    parameter logic [B-1:0] HDR_XOR     = 8'h48,
    parameter bit           CHECK_CKSUM = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         load,
    input  logic [B-1:0] data,
    output logic [7:0]   hour,
    output logic [7:0]   minute,
    output logic [7:0]   second,
    output logic [7:0]   day,
    output logic [7:0]   month,
    output logic [15:0]  year,
    output logic         done,
    output logic         error,
    output logic         busy
);

    state_t       state_r;
    logic [2:0]   field_r;
    logic [2:0]   digit_r;
    logic         frac_r;
    logic         int_ok_r;
    logic [B-1:0] cksum_r;
    logic [7:0]   rx_cksum_r;
    logic [23:0]  time_sh_r;
    logic [7:0]   day_sh_r;
    logic [7:0]   month_sh_r;
    logic [15:0]  year_sh_r;

    logic [3:0]   hex_nib_s;
    logic         hex_valid_s;
    logic         cnt_ok_s;
    logic         is_digit_s;

    nmea_hex_nibble u_hex (
        .ch     (data[7:0]),
        .nibble (hex_nib_s),
        .valid  (hex_valid_s)
    );

    // Classify the current byte against the field being collected.
    always_comb begin
        cnt_ok_s   = field_count_ok(field_r, digit_r, frac_r, int_ok_r);
        is_digit_s = is_dec_digit(data[7:0]);
    end

    assign busy = (state_r != IDLE);

    // Sentence FSM: field tracking, checksum, shadow capture and output publish.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            field_r    <= 3'd0;
            digit_r    <= 3'd0;
            frac_r     <= 1'b0;
            int_ok_r   <= 1'b0;
            cksum_r    <= '0;
            rx_cksum_r <= 8'h00;
            time_sh_r  <= 24'h000000;
            day_sh_r   <= 8'h00;
            month_sh_r <= 8'h00;
            year_sh_r  <= 16'h0000;
            hour       <= 8'h00;
            minute     <= 8'h00;
            second     <= 8'h00;
            day        <= 8'h00;
            month      <= 8'h00;
            year       <= 16'h0000;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (start) begin
                // A re-arm while a sentence is open aborts that sentence.
                error    <= (state_r != IDLE);
                cksum_r  <= HDR_XOR;
                field_r  <= 3'd0;
                digit_r  <= 3'd0;
                frac_r   <= 1'b0;
                int_ok_r <= 1'b0;
                state_r  <= COMMA0;
            end else if (load) begin
                if ((state_r != IDLE) && (data == CH_DOLLAR)) begin
                    error   <= 1'b1;
                    state_r <= IDLE;
                end else begin
                    case (state_r)
                        IDLE: begin
                            state_r <= IDLE;
                        end
                        COMMA0: begin
                            if (data == CH_COMMA) begin
                                cksum_r <= cksum_r ^ data;
                                state_r <= FIELDS;
                            end else begin
                                error   <= 1'b1;
                                state_r <= IDLE;
                            end
                        end
                        FIELDS: begin
                            if (data == CH_STAR) begin
                                if ((field_r == LAST_FIELD) && cnt_ok_s) begin
                                    state_r <= CK_HI;
                                end else begin
                                    error   <= 1'b1;
                                    state_r <= IDLE;
                                end
                            end else begin
                                cksum_r <= cksum_r ^ data;
                                if (data == CH_COMMA) begin
                                    if ((field_r != LAST_FIELD) && cnt_ok_s) begin
                                        field_r  <= field_r + 3'd1;
                                        digit_r  <= 3'd0;
                                        frac_r   <= 1'b0;
                                        int_ok_r <= 1'b0;
                                    end else begin
                                        error   <= 1'b1;
                                        state_r <= IDLE;
                                    end
                                end else if (is_digit_s) begin
                                    digit_r <= digit_inc(digit_r);
                                    case (field_r)
                                        3'd0: begin
                                            // Fraction digits are counted but discarded.
                                            if (!frac_r) begin
                                                time_sh_r <= {time_sh_r[19:0], data[3:0]};
                                            end else begin
                                                time_sh_r <= time_sh_r;
                                            end
                                        end
                                        3'd1:    day_sh_r   <= {day_sh_r[3:0], data[3:0]};
                                        3'd2:    month_sh_r <= {month_sh_r[3:0], data[3:0]};
                                        3'd3:    year_sh_r  <= {year_sh_r[11:0], data[3:0]};
                                        default: year_sh_r  <= year_sh_r;
                                    endcase
                                end else if ((data == CH_MINUS) && (field_r >= 3'd4)) begin
                                    digit_r <= digit_inc(digit_r);
                                end else if ((data == CH_DOT) && (field_r == 3'd0) && !frac_r) begin
                                    // Integer count is judged later, at the field terminator.
                                    int_ok_r <= (digit_r == TIME_DIGITS);
                                    frac_r   <= 1'b1;
                                    digit_r  <= 3'd0;
                                end else begin
                                    error   <= 1'b1;
                                    state_r <= IDLE;
                                end
                            end
                        end
                        CK_HI: begin
                            if (hex_valid_s) begin
                                rx_cksum_r[7:4] <= hex_nib_s;
                                state_r         <= CK_LO;
                            end else begin
                                error   <= 1'b1;
                                state_r <= IDLE;
                            end
                        end
                        CK_LO: begin
                            if (hex_valid_s) begin
                                rx_cksum_r[3:0] <= hex_nib_s;
                                state_r         <= WAIT_CR;
                            end else begin
                                error   <= 1'b1;
                                state_r <= IDLE;
                            end
                        end
                        WAIT_CR: begin
                            if ((data == CH_CR) || (data == CH_LF)) begin
                                if (CHECK_CKSUM && (rx_cksum_r != cksum_r[7:0])) begin
                                    error <= 1'b1;
                                end else begin
                                    hour   <= time_sh_r[23:16];
                                    minute <= time_sh_r[15:8];
                                    second <= time_sh_r[7:0];
                                    day    <= day_sh_r;
                                    month  <= month_sh_r;
                                    year   <= year_sh_r;
                                    done   <= 1'b1;
                                end
                            end else begin
                                error <= 1'b1;
                            end
                            state_r <= IDLE;
                        end
                        default: begin
                            error   <= 1'b1;
                            state_r <= IDLE;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_gpzda_field_parser.sv
// Directed bench for gpzda_field_parser: nominal, gapped, checksum,
// malformed fields, restart, '$' abort and asynchronous reset.
module tb_gpzda_field_parser;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        load;
    logic [7:0]  data;

    logic [7:0]  hour, minute, second, day, month;
    logic [15:0] year;
    logic        done, error, busy;

    logic [7:0]  nc_hour, nc_minute, nc_second, nc_day, nc_month;
    logic [15:0] nc_year;
    logic        nc_done, nc_error, nc_busy;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;
    int both_seen;

    gpzda_field_parser dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .load    (load),
        .data    (data),
        .hour    (hour),
        .minute  (minute),
        .second  (second),
        .day     (day),
        .month   (month),
        .year    (year),
        .done    (done),
        .error   (error),
        .busy    (busy)
    );

    gpzda_field_parser #(.CHECK_CKSUM(1'b0)) dut_nc (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .load    (load),
        .data    (data),
        .hour    (nc_hour),
        .minute  (nc_minute),
        .second  (nc_second),
        .day     (nc_day),
        .month   (nc_month),
        .year    (nc_year),
        .done    (nc_done),
        .error   (nc_error),
        .busy    (nc_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count pulses of the checked instance on the quiet edge.
    always @(negedge clock) begin
        if (done)  done_cnt  = done_cnt + 1;
        if (error) err_cnt   = err_cnt + 1;
        if (done && error) both_seen = both_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic st);
        start = st;
        load  = 1'b1;
        data  = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        load  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_str(input string s, input bit gapped);
        for (int i = 0; i < s.len(); i++) begin
            if (gapped && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 5));
            send(s[i], 1'b0);
        end
    endtask

    function automatic logic [7:0] body_xor(input string s);
        logic [7:0] x;
        x = 8'h48;
        for (int i = 0; i < s.len(); i++) x = x ^ s[i];
        return x;
    endfunction

    function automatic logic [7:0] hex_lc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    localparam string NOMINAL = ",082710.00,16,09,2002,00,00*64";
    localparam string BODY2   = ",235959,31,12,1999,-05,30";

    int d0;
    int e0;
    logic [7:0] cs2;

    initial begin
        checks = 0; errors = 0; done_cnt = 0; err_cnt = 0; both_seen = 0;
        reset_n = 1'b0; start = 1'b0; load = 1'b0; data = 8'h00;
        #12;
        chk("reset_time", {8'h00, hour, minute, second}, 32'h0);
        chk("reset_date", {day, month, year}, 32'h0);
        chk("reset_flags", {29'h0, done, error, busy}, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Nominal sentence, back to back
        send(8'h41, 1'b1);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        send_str(NOMINAL, 1'b0);
        chk("nom_no_early_done", {31'h0, done}, 32'h0);
        send(8'h0D, 1'b0);
        chk("nom_done", {30'h0, done, error}, 32'h2);
        chk("nom_time", {8'h00, hour, minute, second}, 32'h00082710);
        chk("nom_date", {day, month, year}, 32'h16092002);
        idle(1);
        chk("nom_done_pulse", {30'h0, done, busy}, 32'h0);

        // Second sentence: no fraction, signed zone, lowercase checksum, LF
        cs2 = body_xor(BODY2);
        d0 = done_cnt;
        send(8'h41, 1'b1);
        send_str(BODY2, 1'b1);
        send(8'h2A, 1'b0);
        send(hex_lc(cs2[7:4]), 1'b0);
        send(hex_lc(cs2[3:0]), 1'b0);
        send(8'h0A, 1'b0);
        chk("s2_time", {8'h00, hour, minute, second}, 32'h00235959);
        chk("s2_date", {day, month, year}, 32'h31121999);
        idle(1);
        chk("s2_done_count", done_cnt - d0, 32'd1);

        // Gapped nominal sentence
        d0 = done_cnt; e0 = err_cnt;
        send(8'h41, 1'b1);
        send_str(NOMINAL, 1'b1);
        idle(3);
        send(8'h0D, 1'b0);
        chk("gap_time", {8'h00, hour, minute, second}, 32'h00082710);
        chk("gap_date", {day, month, year}, 32'h16092002);
        idle(2);
        chk("gap_done_count", done_cnt - d0, 32'd1);
        chk("gap_err_count", err_cnt - e0, 32'd0);

        // Bad checksum; the no-check instance still publishes
        send(8'h41, 1'b1);
        send_str(",082710.00,16,09,2002,00,00*65", 1'b0);
        send(8'h0D, 1'b0);
        chk("badck_flags", {30'h0, done, error}, 32'h1);
        chk("badck_keep", {day, month, year}, 32'h16092002);
        chk("nock_done", {30'h0, nc_done, nc_error}, 32'h2);
        chk("nock_vals", {nc_hour, nc_minute, nc_second, nc_busy, 7'h0}, 32'h08271000);
        chk("nock_date", {nc_day, nc_month, nc_year}, 32'h16092002);
        idle(1);
        chk("badck_idle", {31'h0, busy}, 32'h0);

        // Five time digits: rejected at the following comma
        send(8'h41, 1'b1);
        send_str(",08271.00", 1'b0);
        chk("short_no_err_yet", {31'h0, error}, 32'h0);
        d0 = done_cnt;
        send(8'h2C, 1'b0);
        chk("short_err", {30'h0, error, busy}, 32'h2);
        send_str("16,09,2002,00,00*64", 1'b0);
        send(8'h0D, 1'b0);
        idle(1);
        chk("short_ignored", {31'h0, busy}, done_cnt - d0);

        // Illegal letter in the day field
        send(8'h41, 1'b1);
        send_str(",082710.00,1", 1'b0);
        chk("x_before", {31'h0, error}, 32'h0);
        send(8'h58, 1'b0);
        chk("x_err", {30'h0, error, busy}, 32'h2);

        // '$' inside a sentence aborts it
        send(8'h41, 1'b1);
        send_str(",08", 1'b0);
        send(8'h24, 1'b0);
        chk("dollar_err", {30'h0, error, busy}, 32'h2);

        // Restart mid-sentence then a full valid sentence
        send(8'h41, 1'b1);
        send_str(",0827", 1'b0);
        send(8'h41, 1'b1);
        chk("restart_err", {30'h0, error, busy}, 32'h3);
        send_str(BODY2, 1'b0);
        send(8'h2A, 1'b0);
        send(hex_lc(cs2[7:4]), 1'b0);
        send(hex_lc(cs2[3:0]), 1'b0);
        send(8'h0D, 1'b0);
        chk("restart_done", {30'h0, done, error}, 32'h2);
        chk("restart_vals", {8'h00, hour, minute, second}, 32'h00235959);
        chk("restart_date", {day, month, year}, 32'h31121999);

        // Asynchronous reset in the middle of FIELDS
        send(8'h41, 1'b1);
        send_str(",0827", 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_time", {8'h00, hour, minute, second}, 32'h0);
        chk("areset_date", {day, month, year}, 32'h0);
        chk("areset_busy", {31'h0, busy}, 32'h0);
        idle(2);
        #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        d0 = done_cnt;
        send_str(NOMINAL, 1'b0);
        chk("post_reset_busy", {31'h0, busy}, 32'h0);
        send(8'h0D, 1'b0);
        idle(1);
        chk("post_reset_no_done", done_cnt - d0, 32'd0);
        chk("post_reset_hour", {24'h0, hour}, 32'h0);

        chk("never_done_and_error", both_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpzda_field_parser.md
Name: gpzda_field_parser

Overview:
- Sits directly downstream of the `$GPZDA` header comparer and shares its `load`/`data` byte stream.
- Armed by the comparer's `resolve` pulse. From then on it consumes the remainder of the sentence: `,hhmmss.ff,dd,mm,yyyy,zh,zm*CS<CR>`.
- Extracts time and date as BCD and verifies the NMEA XOR checksum.
- Publishes a registered timestamp with a one-cycle `done` pulse, or an `error` pulse on any malformed sentence.

Parameters:
- B, 8, bits per byte.
- HDR_XOR, 8'h48, XOR of "GPZDA", used as the checksum seed.
- CHECK_CKSUM, 1, when 0 the checksum is parsed but a mismatch is not flagged.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  header matched; the comparer's `resolve`, coincident with the `load` of the final 'A'.
- load  in  1  `data` valid this cycle.
- data  in  B  ASCII byte.
- hour  out  8  BCD hh.
- minute  out  8  BCD mm.
- second  out  8  BCD ss.
- day  out  8  BCD dd.
- month  out  8  BCD mm.
- year  out  16  BCD yyyy.
- done  out  1  one-cycle pulse; a new timestamp is valid.
- error  out  1  one-cycle pulse; the sentence was rejected.
- busy  out  1  parser is not IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE, all outputs 0, field/digit counters 0, checksum 0.
- Clocking: all state changes on posedge clock. A byte is consumed only when load=1. Idle cycles (load=0) inside a sentence are legal and change nothing.
- start=1 (with load=1): the byte is the header's 'A' and is NOT consumed as a field byte. Actions: checksum <= HDR_XOR, field <= 0, digit <= 0, state <= COMMA0.
- start in any non-IDLE state: pulse error the same edge, then restart as above.
- States and transitions:
  - IDLE: ignore bytes.
  - COMMA0: ',' -> FIELDS; any other byte -> error.
  - FIELDS, for each byte except '*': checksum ^= data.
    - ',' advances field 0..5; a ',' while in field 5 -> error.
    - '*' -> CK_HI; legal only in field 5, else error.
    - Field 0: exactly 6 digits, then optionally '.' followed by 0..3 digits (fraction discarded).
    - Fields 1, 2: exactly 2 digits. Field 3: exactly 4 digits.
    - Fields 4, 5: 0..3 chars from {'-','0'..'9'}; content ignored.
    - Digit counts are checked at ',' and '*'. A wrong count or an illegal character -> error.
  - CK_HI / CK_LO: accept one hex char each ('0'-'9', 'A'-'F', 'a'-'f') into rx_cksum[7:4] / [3:0]; non-hex -> error.
  - WAIT_CR: accept '\r' or '\n'.
    - If CHECK_CKSUM and rx_cksum != checksum -> error.
    - Else copy shadow fields to outputs and pulse done.
    - Either way -> IDLE.
- Any '$' while not IDLE: error, then IDLE. The comparer's `start` may re-arm on that same sentence later.
- Error handling: error pulses 1 cycle, state -> IDLE, outputs keep their previous timestamp.
- Shadow registers: digits are shifted into shadow registers (BCD = data[3:0]). Outputs update only on the done edge.
- Latency: done and error assert the clock edge after the terminating byte is loaded.
- done and error are mutually exclusive and never both 1.
- Width rules:
  - digit counter 3 bits, saturating at 7; a saturated counter is always an invalid count.
  - field index 3 bits.
  - checksum B bits.
- No range checking of values (e.g. hour=25 passes); that check belongs downstream.

Decomposition:
- Shared package `nmea_pkg` holds:
  - ASCII constants: CH_COMMA, CH_STAR, CH_DOLLAR, CH_DOT, CH_MINUS, CH_CR, CH_LF.
  - The state enum {IDLE, COMMA0, FIELDS, CK_HI, CK_LO, WAIT_CR}.
  - The per-field digit limits.
- One natural sub-module, `nmea_hex_nibble`: combinational ASCII-hex to 4-bit value plus a `valid` flag. It is reused by other NMEA parsers.

Test Plan:
- Nominal: start on 'A', then ",082710.00,16,09,2002,00,00*64\r" one byte per cycle. Expect done=1 one cycle after '\r'; outputs 08/27/10, 16, 09, 2002; error=0.
- Gapped load: same sentence with random load=0 gaps (1–5 cycles). Identical outputs and a single done pulse.
- Bad checksum: same sentence with "*65". Expect error=1, done=0, outputs unchanged from the previous run.
  - With CHECK_CKSUM=0, the same stimulus gives done=1.
- Malformed field: ",08271.00,16,…" (5 time digits). Expect error at the following ','; then busy=0.
  - Also the letter 'X' in the day field: error on that byte.
- Mid-sentence restart: after ",0827", assert start with 'A', then send a full valid sentence. Expect an error pulse at the restart and done for the second sentence with the correct values.
- Async reset: pull reset_n low during FIELDS, asynchronously to clock. All outputs read 0 immediately; after release, bytes are ignored until the next start.
